// File: rtl/pipe_field.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_field : scrolling pipe obstacle field with LFSR gaps, bird collision   |
// |              detection and saturating pass score                           |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module pipe_field #(
  parameter int          ROWS     = 8,
  parameter int          COLS     = 8,
  parameter int          GAP      = 3,
  parameter int          SPACING  = 4,
  parameter int          BIRD_COL = COLS - 2,
  parameter logic [7:0]  SEED     = 8'hA5,
  parameter int          SCORE_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       restart,
  input  logic                       pause,
  input  logic                       step,
  input  logic [$clog2(ROWS)-1:0]    bird_row,
  output logic [ROWS-1:0][COLS-1:0]  field,
  output logic                       collision,
  output logic                       pipe_passed,
  output logic [SCORE_W-1:0]         score
);

  localparam int                SP_W      = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int                NGAP      = ROWS - GAP + 1;
  localparam logic [SP_W-1:0]   SP_LAST   = SP_W'(SPACING - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [ROWS-1:0][COLS-1:0] field_q, field_d;
  logic [COLS-1:0]           tag_q, tag_d;
  logic [SP_W-1:0]           sp_q, sp_d;
  logic [7:0]                lfsr_q, lfsr_d;
  logic                      coll_q, coll_d;
  logic                      pass_q, pass_d;
  logic [SCORE_W-1:0]        score_q, score_d;

  logic                      hit_now;
  logic                      accept;
  logic [ROWS-1:0]           new_col;
  logic [31:0]               gap_base;

  always_comb begin
    hit_now = 1'b0;
    if (32'(bird_row) < 32'(ROWS)) hit_now = field_q[bird_row][BIRD_COL];
  end

  // A hit freezes the field in the very cycle it is seen, before collision registers.
  assign accept = step & ~pause & ~(coll_q | hit_now);

  always_comb begin
    gap_base = 32'(lfsr_q) % 32'(NGAP);
    new_col  = '0;
    if (sp_q == '0) begin
      for (int r = 0; r < ROWS; r++) begin
        new_col[r] = !((32'(r) >= gap_base) && (32'(r) < gap_base + 32'(GAP)));
      end
    end
  end

  always_comb begin
    field_d = field_q;
    tag_d   = tag_q;
    sp_d    = sp_q;
    lfsr_d  = lfsr_q;
    coll_d  = coll_q | hit_now;
    pass_d  = 1'b0;
    score_d = score_q;
    if (accept) begin
      for (int r = 0; r < ROWS; r++) begin
        field_d[r] = {field_q[r][COLS-2:0], new_col[r]};
      end
      tag_d  = {tag_q[COLS-2:0], (sp_q == '0)};
      sp_d   = (sp_q == SP_LAST) ? '0 : sp_q + SP_W'(1);
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      pass_d = tag_q[BIRD_COL];
      if (tag_q[BIRD_COL] && (score_q != SCORE_MAX)) score_d = score_q + SCORE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      field_q <= '0;
      tag_q   <= '0;
      sp_q    <= '0;
      lfsr_q  <= SEED;
      coll_q  <= 1'b0;
      pass_q  <= 1'b0;
      score_q <= '0;
    end else if (restart) begin
      // LFSR deliberately keeps running so each new game gets fresh gaps.
      field_q <= '0;
      tag_q   <= '0;
      sp_q    <= '0;
      coll_q  <= 1'b0;
      pass_q  <= 1'b0;
      score_q <= '0;
    end else begin
      field_q <= field_d;
      tag_q   <= tag_d;
      sp_q    <= sp_d;
      lfsr_q  <= lfsr_d;
      coll_q  <= coll_d;
      pass_q  <= pass_d;
      score_q <= score_d;
    end
  end

  assign field       = field_q;
  assign collision   = coll_q;
  assign pipe_passed = pass_q;
  assign score       = score_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_field.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_field : directed scoreboard bench for pipe_field                   |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_field;

  logic              clk = 1'b0;
  logic              reset, restart, pause, step;
  logic [2:0]        bird_row;
  logic [7:0][7:0]   field, field2;
  logic              coll, coll2, pp, pp2;
  logic [7:0]        score;
  logic [1:0]        score2;

  always #5 clk = ~clk;

  pipe_field dut (
    .clk(clk), .reset(reset), .restart(restart), .pause(pause), .step(step),
    .bird_row(bird_row), .field(field), .collision(coll), .pipe_passed(pp), .score(score)
  );

  pipe_field #(.SCORE_W(2)) dut_sat (
    .clk(clk), .reset(reset), .restart(restart), .pause(pause), .step(step),
    .bird_row(bird_row), .field(field2), .collision(coll2), .pipe_passed(pp2), .score(score2)
  );

  typedef struct {
    string       name;
    int          due;
    bit          cf;
    bit          sat;
    logic [63:0] cols;
    logic        coll;
    logic        pp;
    logic [7:0]  sc;
    logic        pp2;
    logic [1:0]  sc2;
  } exp_t;

  exp_t sb[$];
  exp_t it;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Column-major view: byte c holds column c, bit r of the byte is row r.
  function automatic logic [63:0] f2cols(input logic [7:0][7:0] f);
    logic [63:0] cv;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        cv[8*c + r] = f[r][c];
    return cv;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      it = sb.pop_front();
      if (it.due != cyc) begin
        chk({it.name, "_late"}, 64'(cyc), 64'(it.due));
      end else begin
        if (it.cf) chk({it.name, "_field"}, f2cols(field), it.cols);
        chk({it.name, "_coll"},  64'(coll),  64'(it.coll));
        chk({it.name, "_pp"},    64'(pp),    64'(it.pp));
        chk({it.name, "_score"}, 64'(score), 64'(it.sc));
        if (it.sat) begin
          chk({it.name, "_pp2"},    64'(pp2),    64'(it.pp2));
          chk({it.name, "_score2"}, 64'(score2), 64'(it.sc2));
        end
      end
    end
  end

  task automatic expect_f(input string nm, input logic [63:0] cv, input logic c,
                          input logic p, input logic [7:0] s);
    exp_t e;
    e.name = nm; e.due = cyc; e.cf = 1'b1; e.sat = 1'b0; e.cols = cv;
    e.coll = c; e.pp = p; e.sc = s; e.pp2 = 1'b0; e.sc2 = 2'd0;
    sb.push_back(e);
  endtask

  task automatic expect_sat(input string nm, input logic [7:0] s, input logic [1:0] s2);
    exp_t e;
    e.name = nm; e.due = cyc; e.cf = 1'b0; e.sat = 1'b1; e.cols = '0;
    e.coll = 1'b0; e.pp = 1'b1; e.sc = s; e.pp2 = 1'b1; e.sc2 = s2;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Column words are {c7,c6,c5,c4,c3,c2,c1,c0}. Gaps: A5%6=3 -> C7, 54%6=0 -> F8,
  // 4E%6=0 -> F8, EE%6=4 -> 8F, EC%6=2 -> E3, A7%6=5 -> 1F.
  localparam logic [63:0] F_STEP1   = 64'h00_00_00_00_00_00_00_C7;
  localparam logic [63:0] F_STEP5   = 64'h00_00_00_C7_00_00_00_F8;
  localparam logic [63:0] F_STEP6   = 64'h00_00_C7_00_00_00_F8_00;
  localparam logic [63:0] F_STEP7   = 64'h00_C7_00_00_00_F8_00_00;
  localparam logic [63:0] F_STEP8   = 64'hC7_00_00_00_F8_00_00_00;
  localparam logic [63:0] F_RESTART = 64'h00_00_00_00_00_00_00_1F;

  int grow [5] = '{4, 1, 1, 5, 3};

  initial begin
    reset = 1'b1; restart = 1'b0; pause = 1'b0; step = 1'b0; bird_row = 3'd4;
    tick(); tick();
    reset = 1'b0;
    expect_f("reset", 64'd0, 1'b0, 1'b0, 8'd0);

    // Game 1: first pipe, spacing, pass with bird inside the gap.
    do_step();          expect_f("step1",     F_STEP1, 1'b0, 1'b0, 8'd0);
    repeat (4) do_step(); expect_f("spacing", F_STEP5, 1'b0, 1'b0, 8'd0);
    do_step(); do_step(); expect_f("pass_pre", F_STEP7, 1'b0, 1'b0, 8'd0);
    do_step();          expect_f("pass",      F_STEP8, 1'b0, 1'b1, 8'd1);
    tick();             expect_f("pass_after", F_STEP8, 1'b0, 1'b0, 8'd1);

    // Game 2: reset with a concurrent step, then collision at row 0.
    bird_row = 3'd0;
    step = 1'b1; reset = 1'b1; tick(); reset = 1'b0; step = 1'b0;
    expect_f("reset_step", 64'd0, 1'b0, 1'b0, 8'd0);
    repeat (7) do_step(); expect_f("hit_field", F_STEP7, 1'b0, 1'b0, 8'd0);
    do_step();          expect_f("coll_rise", F_STEP7, 1'b1, 1'b0, 8'd0);
    repeat (3) do_step(); expect_f("frozen",  F_STEP7, 1'b1, 1'b0, 8'd0);
    step = 1'b1; restart = 1'b1; tick(); restart = 1'b0; step = 1'b0;
    expect_f("restart", 64'd0, 1'b0, 1'b0, 8'd0);
    do_step();          expect_f("restart_lfsr", F_RESTART, 1'b0, 1'b0, 8'd0);

    // Game 3: pause drops steps.
    bird_row = 3'd4;
    do_reset();
    repeat (5) do_step(); expect_f("pause_pre", F_STEP5, 1'b0, 1'b0, 8'd0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_step(); expect_f("paused", F_STEP5, 1'b0, 1'b0, 8'd0);
    end
    pause = 1'b0;
    do_step();          expect_f("unpause", F_STEP6, 1'b0, 1'b0, 8'd0);

    // Game 4: five passes, bird steered into each gap; SCORE_W=2 instance saturates.
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      int idx;
      idx = ((k - 1) / 4) - 1;
      if (idx < 0) idx = 0;
      bird_row = 3'(grow[idx]);
      do_step();
      if ((k % 4 == 0) && (k >= 8)) begin
        int n;
        n = k / 4 - 1;
        expect_sat("sat", 8'(n), (n > 3) ? 2'd3 : 2'(n));
      end
    end

    tick(); tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: cycle %0d reached without finishing", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pipe_field.md
# pipe_field

Parametrised scrolling obstacle generator for the LED-matrix game. It replaces the fixed 8×8 start-column and shift-column chain with one configurable block. The block builds pipe columns with a pseudo-random gap from an LFSR, inserts them at a programmable spacing and scrolls the field on a tick. It also detects a bird/pipe collision at a fixed column and keeps a saturating pass score. Its output field feeds the collision, pause-overlay and matrix-driver path in the top level.

## Interface
Parameters:
- ROWS, 8, field height; must satisfy ROWS ≥ 2.
- COLS, 8, field width; must satisfy COLS ≥ 2.
- GAP, 3, gap height in rows; must satisfy 1 ≤ GAP < ROWS.
- SPACING, 4, steps between pipe insertions; must be ≥ 1.
- BIRD_COL, COLS-2, column index where the bird sits.
- SEED, 8'hA5, LFSR reset value; must be nonzero.
- SCORE_W, 8, score width.

Ports:
- clk  in  1  system clock; the single clock domain.
- reset  in  1  synchronous, active-high; full initialisation, including the LFSR.
- restart  in  1  synchronous new-game clear; the LFSR is not reinitialised.
- pause  in  1  level; blocks scrolling while high.
- step  in  1  one-cycle scroll tick from the rate counter.
- bird_row  in  $clog2(ROWS)  row the bird currently occupies.
- field  out  [ROWS-1:0][COLS-1:0]  green pixels; field[r][c] = 1 means lit.
- collision  out  1  sticky collision flag.
- pipe_passed  out  1  one-cycle pulse when a pipe leaves BIRD_COL.
- score  out  SCORE_W  number of pipes passed, saturating.

## Operation
- Internal state:
  - field register.
  - tag[COLS-1:0]: tag[c] = 1 when column c holds a pipe.
  - sp_cnt in the range 0..SPACING-1.
  - lfsr[7:0].
  - collision, pipe_passed and score registers.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting left with the feedback bit entering bit 0. It advances exactly once per accepted step.
- gap_base = lfsr % (ROWS-GAP+1), computed from the pre-advance value.
- New column: when sp_cnt == 0 it is a pipe column, lit in every row except rows gap_base..gap_base+GAP-1, and tag_in = 1. Otherwise it is all zeros and tag_in = 0.
- sp_cnt advances on each accepted step and wraps from SPACING-1 to 0.
- Combinational signals:
  - hit_now = (bird_row < ROWS) & field[bird_row][BIRD_COL].
  - frozen = collision | hit_now.
  - accepted step = step & ~pause & ~frozen.
- On an accepted step:
  - field[r][c] <= field[r][c-1] for c ≥ 1, and column 0 <= the new column.
  - tag shifts the same way; column COLS-1 and tag[COLS-1] are discarded.
- collision <= collision | hit_now. Once set, the field, tag, sp_cnt and LFSR hold until reset or restart.
- pipe_passed <= accepted_step & tag[BIRD_COL], using the pre-shift tag value.
- score increments on each pipe_passed cycle and saturates at 2^SCORE_W-1.
- Priority is reset > restart > step.
- restart clears field, tag, sp_cnt, collision, pipe_passed and score. The LFSR keeps its value, so each game's pipe sequence differs.
- A bird_row value ≥ ROWS never causes a hit.

## Timing
- Reset values: field all 0, tag 0, sp_cnt 0, lfsr = SEED, collision 0, pipe_passed 0, score 0.
- Because sp_cnt resets to 0, the first accepted step inserts a pipe.
- All outputs are registered. field updates the cycle after the accepted step.
- collision rises the cycle after hit_now first goes true. A step in that same cycle is ignored, because the hit is checked against the pre-shift field.
- pipe_passed is high for exactly one cycle. score updates in the same cycle that pipe_passed is high.
- A pipe inserted at column 0 reaches BIRD_COL after BIRD_COL further accepted steps.
- step while pause = 1 is dropped, not queued.
- A reset or restart in the middle of a game takes effect at the next edge. Any step in that cycle is ignored.

## Test plan
All scenarios use default parameters; field columns are written as rows 7..0.
- Reset, then one step → column 0 = 8'b11000111 (A5 % 6 = 3, so rows 3–5 are the gap); every other column is 0; score = 0; collision = 0.
- Spacing: after 5 steps from reset → pipes at column 4 and column 0, and columns 1–3 are empty. Column 0 uses gap_base from the LFSR value after four advances; check it against the reference polynomial.
- Pass: bird_row = 4 for 8 steps → no collision; pipe_passed pulses exactly once, on step 8; score = 1.
- Collision:
  - bird_row = 0 for 7 steps → field[0][6] = 1 and collision = 1 on the next cycle.
  - 3 more steps → field unchanged and score = 0.
  - restart → field = 0 and collision = 0; the next step's pipe gap comes from the continued LFSR value, not from SEED.
- Pause: insert 2 pipes, then hold pause = 1 and issue 5 steps → field, score and pipe_passed are unchanged. Release pause and issue one step → the field shifts by exactly one column.
- Saturation: SCORE_W = 2, bird_row kept inside each gap, 5 pipes passed → score goes 1, 2, 3, 3, 3, and pipe_passed still pulses for every pipe.
